// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-stream byte arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} arb_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux_stream_arbiter_rr_grant.sv
// Combinational grant decision: burst lock first, then lone requester, then round-robin.
module rr_grant
  import mux_arb_pkg::*;
#(
  parameter int LOCK_BEATS = 1,
  parameter int CNT_W      = 1
) (
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             last_grant,
  input  arb_state_e       state,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load,
  output logic             grant_valid,
  output logic             grant
);

  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_BEATS);

  always_comb begin
    grant_valid = 1'b0;
    grant       = SRC_A;
    if (load) begin
      if (state == LOCK_A && a_valid && cnt < LOCK_MAX) begin
        grant_valid = 1'b1;
        grant       = SRC_A;
      end else if (state == LOCK_B && b_valid && cnt < LOCK_MAX) begin
        grant_valid = 1'b1;
        grant       = SRC_B;
      end else if (a_valid && !b_valid) begin
        grant_valid = 1'b1;
        grant       = SRC_A;
      end else if (b_valid && !a_valid) begin
        grant_valid = 1'b1;
        grant       = SRC_B;
      end else if (a_valid && b_valid) begin
        grant_valid = 1'b1;
        grant       = ~last_grant;
      end
    end
  end

endmodule

// File: rtl/mux_stream_arbiter.sv
// Two-stream valid/ready arbiter feeding a single registered output slot and the 2:1 mux select.
module mux_stream_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOCK_BEATS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  output logic [DATA_W-1:0] y_data_o,
  output logic              y_valid_o,
  input  logic              y_ready_i,
  output logic              sel_o
);

  localparam int CNT_W = $clog2(LOCK_BEATS + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_BEATS);

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             load;
  logic             grant_valid;
  logic             grant;
  logic             same_src;

  // Refill is allowed whenever the slot is empty or draining; reset masks all handshakes.
  assign load = (~y_valid_o | y_ready_i) & ~reset;

  rr_grant #(
    .LOCK_BEATS (LOCK_BEATS),
    .CNT_W      (CNT_W)
  ) u_rr_grant (
    .a_valid     (a_valid_i),
    .b_valid     (b_valid_i),
    .last_grant  (last_grant),
    .state       (state),
    .cnt         (cnt),
    .load        (load),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign a_ready_o = grant_valid & (grant == SRC_A);
  assign b_ready_o = grant_valid & (grant == SRC_B);

  assign same_src = (state == LOCK_A && grant == SRC_A) ||
                    (state == LOCK_B && grant == SRC_B);

  always_ff @(posedge clk) begin
    if (reset) begin
      y_valid_o  <= 1'b0;
      y_data_o   <= '0;
      sel_o      <= SRC_A;
      last_grant <= SRC_B;
      state      <= IDLE;
      cnt        <= '0;
    end else if (load) begin
      if (grant_valid) begin
        y_data_o   <= (grant == SRC_B) ? b_data_i : a_data_i;
        sel_o      <= grant;
        y_valid_o  <= 1'b1;
        last_grant <= grant;
        if (same_src) begin
          if (cnt + 1'b1 == LOCK_MAX) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else if (LOCK_BEATS > 1) begin
          // A new source (or the first beat after idle) opens a fresh burst.
          state <= (grant == SRC_B) ? LOCK_B : LOCK_A;
          cnt   <= CNT_W'(1);
        end else begin
          state <= IDLE;
          cnt   <= '0;
        end
      end else begin
        y_valid_o <= 1'b0;
        state     <= IDLE;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_arbiter.sv
// Directed bench: one instance in pure round-robin, one with a 3-beat burst lock, sharing stimulus.
module tb_mux_stream_arbiter;
  import mux_arb_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] a_data;
  logic       a_valid;
  logic [7:0] b_data;
  logic       b_valid;
  logic       y_ready;

  logic       a_ready_1, b_ready_1, y_valid_1, sel_1;
  logic [7:0] y_data_1;
  logic       a_ready_3, b_ready_3, y_valid_3, sel_3;
  logic [7:0] y_data_3;

  int vectors;
  int miscompares;

  mux_stream_arbiter #(.DATA_W(8), .LOCK_BEATS(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .a_data_i  (a_data),
    .a_valid_i (a_valid),
    .a_ready_o (a_ready_1),
    .b_data_i  (b_data),
    .b_valid_i (b_valid),
    .b_ready_o (b_ready_1),
    .y_data_o  (y_data_1),
    .y_valid_o (y_valid_1),
    .y_ready_i (y_ready),
    .sel_o     (sel_1)
  );

  mux_stream_arbiter #(.DATA_W(8), .LOCK_BEATS(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .a_data_i  (a_data),
    .a_valid_i (a_valid),
    .a_ready_o (a_ready_3),
    .b_data_i  (b_data),
    .b_valid_i (b_valid),
    .b_ready_o (b_ready_3),
    .y_data_o  (y_data_3),
    .y_valid_o (y_valid_3),
    .y_ready_i (y_ready),
    .sel_o     (sel_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic av, input logic [7:0] ad,
                                input logic bv, input logic [7:0] bd,
                                input logic yr);
    a_valid = av;
    a_data  = ad;
    b_valid = bv;
    b_data  = bd;
    y_ready = yr;
  endtask

  initial begin
    logic [7:0] exp_d;
    logic       exp_s;
    vectors     = 0;
    miscompares = 0;

    // Reset held two cycles while both sources request.
    reset = 1'b1;
    apply_stimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    settle();
    check_output("rst_a_ready", {7'd0, a_ready_1}, 8'h00);
    check_output("rst_b_ready", {7'd0, b_ready_1}, 8'h00);
    tick();
    tick();
    check_output("rst_y_valid", {7'd0, y_valid_1}, 8'h00);
    check_output("rst_y_data", y_data_1, 8'h00);
    check_output("rst_sel", {7'd0, sel_1}, 8'h00);
    check_output("rst_a_ready_h", {7'd0, a_ready_3}, 8'h00);

    // Pure round-robin tie: A first, then strict alternation, one beat per cycle.
    reset = 1'b0;
    settle();
    check_output("tie_a_ready", {7'd0, a_ready_1}, 8'h01);
    check_output("tie_b_ready", {7'd0, b_ready_1}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
      exp_s = (i % 2 == 0) ? 1'b0 : 1'b1;
      check_output($sformatf("tie_data_%0d", i), y_data_1, exp_d);
      check_output($sformatf("tie_sel_%0d", i), {7'd0, sel_1}, {7'd0, exp_s});
      check_output($sformatf("tie_valid_%0d", i), {7'd0, y_valid_1}, 8'h01);
    end

    // Backpressure: load 5A, stall three cycles, then release.
    apply_stimulus(1'b1, 8'h5A, 1'b0, 8'h22, 1'b1);
    tick();
    check_output("bp_load", y_data_1, 8'h5A);
    apply_stimulus(1'b1, 8'h5B, 1'b0, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_output($sformatf("bp_a_ready_%0d", i), {7'd0, a_ready_1}, 8'h00);
      tick();
      check_output($sformatf("bp_data_%0d", i), y_data_1, 8'h5A);
      check_output($sformatf("bp_sel_%0d", i), {7'd0, sel_1}, 8'h00);
      check_output($sformatf("bp_valid_%0d", i), {7'd0, y_valid_1}, 8'h01);
    end
    y_ready = 1'b1;
    settle();
    check_output("bp_release_ready", {7'd0, a_ready_1}, 8'h01);
    tick();
    check_output("bp_next_beat", y_data_1, 8'h5B);

    // Drain with nothing offered: slot empties, data/sel hold.
    apply_stimulus(1'b0, 8'h5B, 1'b0, 8'h22, 1'b1);
    tick();
    check_output("drain_valid", {7'd0, y_valid_1}, 8'h00);
    check_output("drain_data", y_data_1, 8'h5B);

    // Single source B.
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'hC3, 1'b1);
    settle();
    check_output("single_a_ready", {7'd0, a_ready_1}, 8'h00);
    check_output("single_b_ready", {7'd0, b_ready_1}, 8'h01);
    tick();
    check_output("single_c3", y_data_1, 8'hC3);
    check_output("single_sel0", {7'd0, sel_1}, 8'h01);
    b_data = 8'hC4;
    settle();
    check_output("single_a_ready2", {7'd0, a_ready_1}, 8'h00);
    tick();
    check_output("single_c4", y_data_1, 8'hC4);
    check_output("single_sel1", {7'd0, sel_1}, 8'h01);

    // Burst lock of three beats on the locked instance.
    reset = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    reset = 1'b0;
    apply_stimulus(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_s = (i >= 3 && i < 6) ? 1'b1 : 1'b0;
      exp_d = exp_s ? 8'hB0 : 8'hA0;
      check_output($sformatf("burst_sel_%0d", i), {7'd0, sel_3}, {7'd0, exp_s});
      check_output($sformatf("burst_data_%0d", i), y_data_3, exp_d);
    end
    tick();
    check_output("burst_a2", {7'd0, sel_3}, 8'h00);
    a_valid = 1'b0;
    tick();
    check_output("drop_b", {7'd0, sel_3}, 8'h01);
    a_valid = 1'b1;
    // Lock has moved to B, so B keeps the grant despite A returning.
    tick();
    check_output("lock_b_2", {7'd0, sel_3}, 8'h01);
    tick();
    check_output("lock_b_3", {7'd0, sel_3}, 8'h01);
    tick();
    check_output("lock_end_a", {7'd0, sel_3}, 8'h00);

    // Reset in the middle of a stall.
    apply_stimulus(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    tick();
    check_output("ms_load", y_data_3, 8'h77);
    y_ready = 1'b0;
    tick();
    check_output("ms_hold", y_data_3, 8'h77);
    check_output("ms_hold_valid", {7'd0, y_valid_3}, 8'h01);
    reset = 1'b1;
    apply_stimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    settle();
    check_output("ms_rst_a_ready", {7'd0, a_ready_3}, 8'h00);
    check_output("ms_rst_b_ready", {7'd0, b_ready_3}, 8'h00);
    tick();
    check_output("ms_rst_valid", {7'd0, y_valid_3}, 8'h00);
    check_output("ms_rst_data", y_data_3, 8'h00);
    check_output("ms_rst_valid_rr", {7'd0, y_valid_1}, 8'h00);
    reset = 1'b0;
    y_ready = 1'b1;
    tick();
    check_output("ms_first_data", y_data_3, 8'h11);
    check_output("ms_first_sel", {7'd0, sel_3}, 8'h00);
    check_output("ms_first_sel_rr", {7'd0, sel_1}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
